// File: rtl/sha_work_regs.sv
// SHA-2 working-variable bank a..h with round counter and feed-forward digest.
// All state changes happen on the falling edge of clk; rst clears everything asynchronously.
module sha_work_regs #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 64,
  parameter int RND_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*WORD_W-1:0]   H_in,
  input  logic [WORD_W-1:0]     t1_in,
  input  logic [WORD_W-1:0]     t2_in,
  output logic [8*WORD_W-1:0]   work_out,
  output logic [RND_W-1:0]      round_idx,
  output logic                  busy,
  output logic                  done,
  output logic [8*WORD_W-1:0]   digest
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_round;
  logic              w_final;
  logic [WORD_W-1:0] r_var   [8];
  logic [WORD_W-1:0] r_hsave [8];
  logic [WORD_W-1:0] r_dig   [8];
  logic [RND_W-1:0]  r_rnd;
  logic              r_done;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_round = 1'b0;
    w_final = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        w_round = 1'b1;
        if (r_rnd == LAST_RND) w_next = S_FINAL;
      end
      S_FINAL: begin
        w_final = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_var[i]   <= '0;
        r_hsave[i] <= '0;
        r_dig[i]   <= '0;
      end
      r_rnd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_load) begin
        // word 0 (a / H0) sits in the most significant slice
        for (int unsigned i = 0; i < 8; i++) begin
          r_var[i]   <= H_in[(7-i)*WORD_W +: WORD_W];
          r_hsave[i] <= H_in[(7-i)*WORD_W +: WORD_W];
        end
        r_rnd <= '0;
      end else if (w_round) begin
        r_var[0] <= t1_in + t2_in;
        r_var[1] <= r_var[0];
        r_var[2] <= r_var[1];
        r_var[3] <= r_var[2];
        r_var[4] <= r_var[3] + t1_in;
        r_var[5] <= r_var[4];
        r_var[6] <= r_var[5];
        r_var[7] <= r_var[6];
        r_rnd    <= (r_rnd == LAST_RND) ? '0 : r_rnd + RND_W'(1);
      end else if (w_final) begin
        for (int unsigned i = 0; i < 8; i++) begin
          r_dig[i] <= r_hsave[i] + r_var[i];
        end
      end
    end
  end

  always_comb begin
    work_out = '0;
    digest   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      work_out[(7-i)*WORD_W +: WORD_W] = r_var[i];
      digest[(7-i)*WORD_W +: WORD_W]   = r_dig[i];
    end
  end

  assign round_idx = r_rnd;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_sha_work_regs.sv
// Bench for sha_work_regs: SHA-256 and SHA-512 instances, queued expectations
// from an array-level round model, plus the SHA-256 "abc" known answer.
module tb_sha_work_regs;

  localparam logic [255:0] IV256  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    logic [511:0] dig;
    logic [511:0] fin;
    int unsigned  done_edge;
  } exp_t;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         start_a = 1'b0;
  logic [255:0] h_a     = '0;
  logic [31:0]  t1_a    = '0;
  logic [31:0]  t2_a    = '0;
  logic [255:0] work_a;
  logic [255:0] dig_a;
  logic [6:0]   ridx_a;
  logic         busy_a;
  logic         done_a;
  logic         start_b = 1'b0;
  logic [511:0] h_b     = '0;
  logic [63:0]  t1_b    = '0;
  logic [63:0]  t2_b    = '0;
  logic [511:0] work_b;
  logic [511:0] dig_b;
  logic [6:0]   ridx_b;
  logic         busy_b;
  logic         done_b;

  int unsigned checks   = 0;
  int unsigned errors   = 0;
  int unsigned edge_cnt = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [63:0] t1_tab_a [64];
  logic [63:0] t2_tab_a [64];
  logic [63:0] t1_tab_b [80];
  logic [63:0] t2_tab_b [80];
  logic [31:0] wsch     [64];
  bit          sha_mode = 1'b0;

  sha_work_regs #(.WORD_W(32), .NUM_ROUNDS(64), .RND_W(7)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .H_in(h_a), .t1_in(t1_a), .t2_in(t2_a),
    .work_out(work_a), .round_idx(ridx_a), .busy(busy_a), .done(done_a), .digest(dig_a));

  sha_work_regs #(.WORD_W(64), .NUM_ROUNDS(80), .RND_W(7)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .H_in(h_b), .t1_in(t1_b), .t2_in(t2_b),
    .work_out(work_b), .round_idx(ridx_b), .busy(busy_b), .done(done_b), .digest(dig_b));

  always #5 clk = ~clk;
  always @(negedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: eight words in an array, shifted once per round with the T1/T2 tables.
  function automatic void model(input bit big, input logic [511:0] h,
                                output logic [511:0] dig, output logic [511:0] fin);
    int unsigned  w, n;
    logic [63:0]  mask, x, y;
    logic [63:0]  hv [8];
    logic [63:0]  v  [8];
    logic [63:0]  nv [8];
    logic [511:0] tmp;
    w    = big ? 64 : 32;
    n    = big ? 80 : 64;
    mask = big ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int unsigned i = 0; i < 8; i++) begin
      tmp   = h >> ((7 - i) * w);
      hv[i] = tmp[63:0] & mask;
      v[i]  = hv[i];
    end
    for (int unsigned r = 0; r < n; r++) begin
      if (big) begin x = t1_tab_b[r]; y = t2_tab_b[r]; end
      else     begin x = t1_tab_a[r]; y = t2_tab_a[r]; end
      nv[0] = (x + y) & mask;
      nv[1] = v[0];
      nv[2] = v[1];
      nv[3] = v[2];
      nv[4] = (v[3] + x) & mask;
      nv[5] = v[4];
      nv[6] = v[5];
      nv[7] = v[6];
      v = nv;
    end
    dig = '0;
    fin = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      dig = dig | (512'((hv[i] + v[i]) & mask) << ((7 - i) * w));
      fin = fin | (512'(v[i]) << ((7 - i) * w));
    end
  endfunction

  function automatic void push_exp(input bit big, input logic [511:0] h, input int unsigned acc);
    exp_t        e;
    logic [255:0] dg, iv;
    if (!big && sha_mode) begin
      dg    = ABC256;
      iv    = IV256;
      e.dig = 512'(dg);
      e.fin = '0;
      for (int unsigned i = 0; i < 8; i++)
        e.fin[(7-i)*32 +: 32] = dg[(7-i)*32 +: 32] - iv[(7-i)*32 +: 32];
    end else begin
      model(big, h, e.dig, e.fin);
    end
    e.done_edge = acc + (big ? 81 : 65);
    if (big) q_b.push_back(e);
    else     q_a.push_back(e);
  endfunction

  task automatic fill(input bit big, input int mode);
    logic [63:0] x, y;
    for (int unsigned r = 0; r < (big ? 80 : 64); r++) begin
      case (mode)
        0:       begin x = '0; y = '0; end
        1:       begin x = '0; y = 64'd1; end
        default: begin x = {32'($urandom), 32'($urandom)}; y = {32'($urandom), 32'($urandom)}; end
      endcase
      if (big) begin
        t1_tab_b[r] = x;
        t2_tab_b[r] = y;
      end else begin
        t1_tab_a[r] = {32'd0, x[31:0]};
        t2_tab_a[r] = {32'd0, y[31:0]};
      end
    end
  endtask

  task automatic wait_idle(input bit big);
    int k = 0;
    while ((big ? busy_b : busy_a) && k < 300) begin @(posedge clk); k++; end
    if (k >= 300) check("idle_timeout", 512'(big ? busy_b : busy_a), 512'(0));
  endtask

  task automatic wait_ridx(input bit big, input int unsigned val);
    int k = 0;
    while (int'(big ? ridx_b : ridx_a) != int'(val) && k < 300) begin @(posedge clk); k++; end
    if (k >= 300) check("ridx_timeout", 512'(big ? ridx_b : ridx_a), 512'(val));
  endtask

  task automatic drain(input bit big);
    int k = 0;
    while ((big ? q_b.size() : q_a.size()) != 0 && k < 300) begin @(posedge clk); k++; end
    if (k >= 300) check("drain_timeout", 512'(big ? q_b.size() : q_a.size()), 512'(0));
  endtask

  task automatic issue(input bit big, input logic [511:0] h, output int unsigned acc);
    logic [511:0] r;
    wait_idle(big);
    @(posedge clk);
    acc = edge_cnt + 1;
    push_exp(big, h, acc);
    if (big) begin h_b = h; start_b = 1'b1; end
    else     begin h_a = h[255:0]; start_a = 1'b1; end
    @(posedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    r       = rand512();
    h_a     = r[255:0];
    h_b     = rand512();
  endtask

  // External round logic: real SHA-256 T1/T2 in sha_mode, otherwise per-round tables.
  logic [31:0] dv [8];
  logic [31:0] d_s1, d_ch, d_s0, d_maj;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) dv[i] = work_a[(7-i)*32 +: 32];
    if (sha_mode) begin
      d_s1  = ror(dv[4], 6) ^ ror(dv[4], 11) ^ ror(dv[4], 25);
      d_ch  = (dv[4] & dv[5]) ^ (~dv[4] & dv[6]);
      d_s0  = ror(dv[0], 2) ^ ror(dv[0], 13) ^ ror(dv[0], 22);
      d_maj = (dv[0] & dv[1]) ^ (dv[0] & dv[2]) ^ (dv[1] & dv[2]);
      t1_a  = dv[7] + d_s1 + d_ch + K256[ridx_a[5:0]] + wsch[ridx_a[5:0]];
      t2_a  = d_s0 + d_maj;
    end else begin
      t1_a = t1_tab_a[ridx_a[5:0]][31:0];
      t2_a = t2_tab_a[ridx_a[5:0]][31:0];
    end
    t1_b = t1_tab_b[ridx_b];
    t2_b = t2_tab_b[ridx_b];
  end

  logic       pb_a = 1'b0, pd_a = 1'b0;
  logic [6:0] pr_a = '0;
  exp_t       ea;
  always @(posedge clk) begin
    if (rst) begin
      pb_a <= 1'b0; pd_a <= 1'b0; pr_a <= '0;
    end else begin
      if (busy_a && pb_a)  check("round_seq_a", 512'(ridx_a), 512'((int'(pr_a) + 1) % 64));
      if (busy_a && !pb_a) check("round_first_a", 512'(ridx_a), 512'(0));
      if (done_a) begin
        check("done_width_a", 512'(pd_a), 512'(0));
        if (q_a.size() == 0) check("spurious_done_a", 512'(done_a), 512'(0));
        else begin
          ea = q_a.pop_front();
          check("digest_a", 512'(dig_a), ea.dig);
          check("work_a", 512'(work_a), ea.fin);
          check("done_edge_a", 512'(edge_cnt), 512'(ea.done_edge));
        end
      end
      pb_a <= busy_a; pr_a <= ridx_a; pd_a <= done_a;
    end
  end

  logic       pb_b = 1'b0, pd_b = 1'b0;
  logic [6:0] pr_b = '0;
  exp_t       eb;
  always @(posedge clk) begin
    if (rst) begin
      pb_b <= 1'b0; pd_b <= 1'b0; pr_b <= '0;
    end else begin
      if (busy_b && pb_b)  check("round_seq_b", 512'(ridx_b), 512'((int'(pr_b) + 1) % 80));
      if (busy_b && !pb_b) check("round_first_b", 512'(ridx_b), 512'(0));
      if (done_b) begin
        check("done_width_b", 512'(pd_b), 512'(0));
        if (q_b.size() == 0) check("spurious_done_b", 512'(done_b), 512'(0));
        else begin
          eb = q_b.pop_front();
          check("digest_b", dig_b, eb.dig);
          check("work_b", work_b, eb.fin);
          check("done_edge_b", 512'(edge_cnt), 512'(eb.done_edge));
        end
      end
      pb_b <= busy_b; pr_b <= ridx_b; pd_b <= done_b;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned  acc;
    logic [511:0] h2;
    logic [511:0] r;
    fill(0, 0);
    fill(1, 0);
    for (int t = 0; t < 64; t++) wsch[t] = '0;
    wsch[0]  = 32'h61626380;
    wsch[15] = 32'h00000018;
    for (int t = 16; t < 64; t++)
      wsch[t] = (ror(wsch[t-2], 17) ^ ror(wsch[t-2], 19) ^ (wsch[t-2] >> 10)) + wsch[t-7]
              + (ror(wsch[t-15], 7) ^ ror(wsch[t-15], 18) ^ (wsch[t-15] >> 3)) + wsch[t-16];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    check("reset_busy_a", 512'(busy_a), 512'(0));
    check("reset_done_a", 512'(done_a), 512'(0));
    check("reset_ridx_a", 512'(ridx_a), 512'(0));
    check("reset_work_a", 512'(work_a), 512'(0));
    check("reset_digest_a", 512'(dig_a), 512'(0));
    check("reset_busy_b", 512'(busy_b), 512'(0));
    check("reset_work_b", work_b, 512'(0));
    check("reset_digest_b", dig_b, 512'(0));
    rst = 1'b0;
    @(posedge clk);

    fill(0, 0); issue(0, 512'(IV256), acc); drain(0);
    fill(0, 1); issue(0, '1, acc); drain(0);
    sha_mode = 1'b1; issue(0, 512'(IV256), acc); drain(0); sha_mode = 1'b0;

    for (int n = 0; n < 4; n++) begin
      fill(0, 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(0, rand512(), acc);
      drain(0);
    end

    // abort a block at round 30; its expectation is withdrawn
    fill(0, 2);
    issue(0, rand512(), acc);
    wait_ridx(0, 30);
    rst = 1'b1;
    #1;
    check("abort_busy", 512'(busy_a), 512'(0));
    check("abort_work", 512'(work_a), 512'(0));
    check("abort_digest", 512'(dig_a), 512'(0));
    check("abort_ridx", 512'(ridx_a), 512'(0));
    q_a.delete(q_a.size() - 1);
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    fill(0, 2); issue(0, rand512(), acc); drain(0);

    // start pulses mid-block are ignored; start held through done chains the next block
    fill(0, 2);
    issue(0, rand512(), acc);
    wait_ridx(0, 5);  start_a = 1'b1; @(posedge clk); start_a = 1'b0;
    wait_ridx(0, 40); start_a = 1'b1; @(posedge clk); start_a = 1'b0;
    wait_ridx(0, 60);
    h2      = rand512();
    h_a     = h2[255:0];
    start_a = 1'b1;
    push_exp(0, h2, acc + 66);
    for (int k = 0; k < 300 && edge_cnt < acc + 66; k++) @(posedge clk);
    start_a = 1'b0;
    r       = rand512();
    h_a     = r[255:0];
    drain(0);

    fill(1, 1); issue(1, '1, acc); drain(1);
    fill(1, 0); issue(1, rand512(), acc); drain(1);
    for (int n = 0; n < 3; n++) begin
      fill(1, 2);
      issue(1, rand512(), acc);
      drain(1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_work_regs.md
Name: sha_work_regs

Overview:
Parametrised SHA-2 working-variable register bank a..h for the hash core. It holds all eight working words in one block and loads them from the intermediate hash on start. It applies one compression-round shift/update per clock, counts rounds, and performs the final feed-forward addition into a digest. External round logic supplies T1/T2 combinationally from this block's outputs and round index.

Parameters:
WORD_W, 32, width of each working word (32 for SHA-256, 64 for SHA-512)
NUM_ROUNDS, 64, compression rounds per block (64 SHA-256, 80 SHA-512)
RND_W, 7, width of round counter; must satisfy 2^RND_W > NUM_ROUNDS

Ports:
clk  input  1  clock; all state updates on falling edge of clk
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin a block; sampled only in IDLE
H_in  input  8*WORD_W  intermediate hash H0..H7, H0 in MSBs [8W-1:7W]
t1_in  input  WORD_W  T1 for current round from external round logic
t2_in  input  WORD_W  T2 for current round from external round logic
work_out  output  8*WORD_W  current a..h, a in MSBs, h in LSBs
round_idx  output  RND_W  current round number, for K/W lookup
busy  output  1  high in ROUND and FINAL states
done  output  1  one-cycle pulse when digest is updated
digest  output  8*WORD_W  feed-forward result H_i + var_i, same packing as H_in

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. All registers update on the falling clock edge.
- Reset (rst=1, async): state=IDLE; a..h=0; saved H=0; round_idx=0; busy=0; done=0; digest=0. Asserting rst mid-round aborts the block with no digest update.
- State IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: a..h<=H_in words, saved H<=H_in, round_idx<=0, go ROUND.
  - start=0: hold all registers.
- State ROUND, one round per edge:
  - h<=g, g<=f, f<=e, e<=d+t1_in, d<=c, c<=b, b<=a, a<=t1_in+t2_in.
  - All additions mod 2^WORD_W; carries discarded.
  - round_idx increments each edge.
  - When round_idx==NUM_ROUNDS-1, apply the update, then round_idx<=0 and go FINAL.
- State FINAL, one edge:
  - digest word i <= saved H word i + working word i, mod 2^WORD_W.
  - done<=1 for exactly one cycle, go IDLE.
  - a..h hold their final round values until the next start.
- start while busy (ROUND/FINAL) is ignored, not queued. start asserted during the done cycle is accepted, since the state is IDLE then.
- H_in is sampled only on the accepting edge; later changes have no effect on the block in flight.
- digest holds its value until the next FINAL or reset.
- Latency: edge 0 accepts start. Edges 1..NUM_ROUNDS apply rounds. Edge NUM_ROUNDS+1 is FINAL, so digest and done are visible after it. Total 66 edges for SHA-256.
- Back-to-back blocks: the minimum start-to-start spacing is NUM_ROUNDS+2 edges.
- t1_in/t2_in are treated as valid whenever state=ROUND. There is no stall input; the external logic must be combinational from work_out and round_idx.

Test Plan:
1. Zero rounds: H_in=6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, t1=t2=0 throughout.
   -> a..h all 0 after 8 rounds; done after edge 65; digest==H_in.
2. Wrap-around: H_in all FFFFFFFF, t1_in=0, t2_in=1.
   -> after 64 rounds a..h all 00000001; digest all 00000000; done pulse one cycle wide.
3. Full SHA-256 "abc" with behavioural T1/T2 model and standard K/W.
   -> digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
4. Reset mid-block: assert rst at round 30.
   -> busy=0, work_out=0, digest=0 immediately (async). A subsequent start runs a full 64 rounds.
5. Start while busy: pulse start at rounds 5 and 40.
   -> ignored; round_idx sequence is unbroken; exactly one done. Start held high through done begins the next block on the edge after done.
6. SHA-512 configuration (WORD_W=64, NUM_ROUNDS=80, RND_W=7), "abc" vector.
   -> digest = ddaf35a1...a54ca49f; done after edge 81.
